sseg_scan_driver: RTL and testbench

Parametrised time-multiplexed seven-segment driver, next generation of the 4-digit BCD display driver. It supports N digits, a programmable per-digit refresh period, per-digit decimal points, leading-zero blanking, an invalid-BCD indication and a display enable. Input data is snapshotted once per full scan so digits never tear. It sits between the BCD datapath (counters/converters) and the board's common-anode display pins.

---
 rtl/sseg_scan_if.sv | 48 ++++
 rtl/sseg_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_sseg_scan_driver.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sseg_scan_if.sv
// -----------------------------------------------------------------------------
// sseg_scan_if
// Bundle of signals between the BCD datapath and the seven-segment scan driver.
//
// Optional feature macro: BRIGHTNESS_PWM_EN (adds the 4-bit duty input).
//
// Signals:
//   en        display enable, 1 = on
//   blank_lz  1 = blank leading zero digits
//   bcd_in    packed BCD, digit k = bcd_in[4k+3:4k], digit 0 least significant
//   dp_in     decimal point request per digit, 1 = lit
//   duty      (BRIGHTNESS_PWM_EN only) brightness, anode on while pwm_cnt <= duty
//   sseg_a_o  anode selects, active-low
//   sseg_c_o  cathodes {g,f,e,d,c,b,a}, active-low
//   sseg_dp_o decimal point cathode, active-low
//
// Modports: master = datapath/bench side, slave = driver side.
// -----------------------------------------------------------------------------
interface sseg_scan_if #(
  parameter int N_DIGITS = 4
);
  logic                    en;
  logic                    blank_lz;
  logic [4*N_DIGITS-1:0]   bcd_in;
  logic [N_DIGITS-1:0]     dp_in;
`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]              duty;
`endif
  logic [N_DIGITS-1:0]     sseg_a_o;
  logic [6:0]              sseg_c_o;
  logic                    sseg_dp_o;

  modport master (
`ifdef BRIGHTNESS_PWM_EN
    output duty,
`endif
    output en, blank_lz, bcd_in, dp_in,
    input  sseg_a_o, sseg_c_o, sseg_dp_o
  );

  modport slave (
`ifdef BRIGHTNESS_PWM_EN
    input  duty,
`endif
    input  en, blank_lz, bcd_in, dp_in,
    output sseg_a_o, sseg_c_o, sseg_dp_o
  );
endinterface

// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
// Time-multiplexed driver for an N-digit common-anode seven-segment display.
// A prescaler holds each digit active for REFRESH_DIV cycles; the BCD and
// decimal-point inputs are snapshotted once per full scan (when the digit
// index wraps back to 0) so a displayed number never tears. Supports leading
// zero blanking, a dash for codes 10..15, and a display enable.
//
// Optional feature macro: BRIGHTNESS_PWM_EN
//   Defined   : a free-running 4-bit pwm counter gates the active anode, which
//               is low only while pwm_cnt <= bus.duty.
//   Undefined : the active anode is low for the whole digit period.
//
// Ports:
//   clk  system clock
//   rst  asynchronous reset, active-high
//   bus  sseg_scan_if.slave (inputs en/blank_lz/bcd_in/dp_in[/duty],
//        registered outputs sseg_a_o/sseg_c_o/sseg_dp_o)
// -----------------------------------------------------------------------------
module sseg_scan_driver #(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  sseg_scan_if.slave  bus
);

  localparam int PW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  // Active-low patterns {g,f,e,d,c,b,a}; codes 10..15 show a dash.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  // Scan state
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] snap_bcd_q, snap_bcd_d;
  logic [N_DIGITS-1:0]   snap_dp_q, snap_dp_d;

  // Registered pin drivers
  logic [N_DIGITS-1:0]   an_q, an_d;
  logic [6:0]            cath_q, cath_d;
  logic                  dp_q, dp_d;

`ifdef BRIGHTNESS_PWM_EN
  logic [3:0]            pwm_q, pwm_d;
`endif

  logic                  tick;
  logic                  wrap;
  logic                  pwm_on;
  logic                  zeros_above;
  logic [N_DIGITS-1:0]   lz_blank;
  logic [3:0]            cur_digit;
  logic                  cur_blank;

  // Prescaler, digit index and per-scan snapshot
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path can leave it unassigned and infer a latch.
    tick       = (presc_q == PRESC_LAST);
    wrap       = tick && (idx_q == IDX_LAST);
    presc_d    = tick ? '0 : presc_q + 1'b1;
    idx_d      = idx_q;
    snap_bcd_d = snap_bcd_q;
    snap_dp_d  = snap_dp_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    // Capture only when the scan restarts so all digits come from one sample.
    if (wrap) begin
      snap_bcd_d = bus.bcd_in;
      snap_dp_d  = bus.dp_in;
    end
  end

  // Leading-zero mask: a digit is blankable when it and every digit above it
  // are zero. Digit 0 always stays visible.
  always_comb begin
    zeros_above = 1'b1;
    lz_blank    = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      zeros_above = zeros_above & (snap_bcd_q[4*k +: 4] == 4'd0);
      lz_blank[k] = zeros_above;
    end
    lz_blank[0] = 1'b0;
  end

`ifdef BRIGHTNESS_PWM_EN
  always_comb begin
    pwm_d  = pwm_q + 4'd1;
    pwm_on = (pwm_q <= bus.duty);
  end
`else
  always_comb begin
    pwm_on = 1'b1;
  end
`endif

  // Output decode from the current index and snapshot
  always_comb begin
    cur_digit = snap_bcd_q[{idx_q, 2'b00} +: 4];
    cur_blank = bus.blank_lz && lz_blank[idx_q];
    an_d      = '1;
    cath_d    = 7'h7F;
    dp_d      = 1'b1;
    if (bus.en) begin
      if (pwm_on) begin
        an_d = ~(N_DIGITS'(1) << idx_q);
      end
      if (!cur_blank) begin
        cath_d = seg_decode(cur_digit);
        dp_d   = ~snap_dp_q[idx_q];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the snapshot registers are reset as well, so the first scan after
    // reset shows a defined all-zero number instead of power-up garbage.
    if (rst) begin
      presc_q    <= '0;
      idx_q      <= '0;
      snap_bcd_q <= '0;
      snap_dp_q  <= '0;
      an_q       <= '1;
      cath_q     <= 7'h7F;
      dp_q       <= 1'b1;
`ifdef BRIGHTNESS_PWM_EN
      pwm_q      <= '0;
`endif
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      snap_bcd_q <= snap_bcd_d;
      snap_dp_q  <= snap_dp_d;
      an_q       <= an_d;
      cath_q     <= cath_d;
      dp_q       <= dp_d;
`ifdef BRIGHTNESS_PWM_EN
      pwm_q      <= pwm_d;
`endif
    end
  end

  assign bus.sseg_a_o  = an_q;
  assign bus.sseg_c_o  = cath_q;
  assign bus.sseg_dp_o = dp_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_sseg_scan_driver
// Directed bench for sseg_scan_driver with N_DIGITS=4, REFRESH_DIV=4.
// Expected display states are pushed to a scoreboard queue when stimulus is
// set up and popped/compared once per clock, sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_sseg_scan_driver;

  localparam int N   = 4;
  localparam int DIV = 4;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] c;
    logic       dp;
  } disp_t;

  localparam disp_t RESET_VAL = '{an: 4'hF, c: 7'h7F, dp: 1'b1};

  logic clk = 1'b0;
  logic rst = 1'b0;

  sseg_scan_if #(.N_DIGITS(N)) bus_if ();

  sseg_scan_driver #(.N_DIGITS(N), .REFRESH_DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  disp_t sb[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    exp_cyc     = 0;   // cycles since reset release, 1-based in model
  string cur_tag     = "reset";

  function automatic logic [6:0] ref_seg(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'd0: s = 7'b1000000;
      4'd1: s = 7'b1111001;
      4'd2: s = 7'b0100100;
      4'd3: s = 7'b0110000;
      4'd4: s = 7'b0011001;
      4'd5: s = 7'b0010010;
      4'd6: s = 7'b0000010;
      4'd7: s = 7'b1111000;
      4'd8: s = 7'b0000000;
      4'd9: s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  // Expected pins while digit k of the snapshot (bcd, dp) is shown in
  // display cycle cyc.
  function automatic disp_t model(input logic [15:0] bcd, input logic [3:0] dp,
                                  input bit lz, input bit on, input int k,
                                  input int cyc);
    disp_t       r;
    logic [15:0] sh;
    r  = RESET_VAL;
    if (!on) return r;
    r.an[k] = 1'b0;
`ifdef BRIGHTNESS_PWM_EN
    if (((cyc - 1) % 16) > int'(bus_if.duty)) r.an = 4'hF;
`endif
    sh = bcd >> (4 * k);
    if (lz && k != 0 && sh == 16'h0) return r;
    r.c  = ref_seg(sh[3:0]);
    r.dp = ~dp[k];
    return r;
  endfunction

  // Push n cycles of a scan (each digit held DIV cycles); cycles with index
  // in [off_lo, off_hi) are expected blank because en is low.
  task automatic push_scan(input logic [15:0] bcd, input logic [3:0] dp,
                           input bit lz, input int n,
                           input int off_lo, input int off_hi);
    for (int i = 0; i < n; i++) begin
      exp_cyc++;
      sb.push_back(model(bcd, dp, lz, !(i >= off_lo && i < off_hi), i / DIV,
                         exp_cyc));
    end
  endtask

  task automatic cmp();
    disp_t e, o;
    vectors++;
    o = {bus_if.sseg_a_o, bus_if.sseg_c_o, bus_if.sseg_dp_o};
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL %s: scoreboard empty, observed an=%b c=%b dp=%b",
             cur_tag, o.an, o.c, o.dp);
    end else begin
      e = sb.pop_front();
      assert (o === e) else begin
        miscompares++;
        $error("FAIL %s: observed an=%b c=%b dp=%b, expected an=%b c=%b dp=%b",
               cur_tag, o.an, o.c, o.dp, e.an, e.c, e.dp);
      end
    end
  endtask

  task automatic run(input int n);
    repeat (n) begin
      @(posedge clk);
      @(negedge clk);
      cmp();
    end
  endtask

  initial begin
    bus_if.en       = 1'b1;
    bus_if.blank_lz = 1'b0;
    bus_if.bcd_in   = 16'h1234;
    bus_if.dp_in    = 4'b0000;
`ifdef BRIGHTNESS_PWM_EN
    bus_if.duty     = 4'd15;
`endif

    // Reset values, asynchronously and across a clock edge
    #1 rst = 1'b1;
    #2;
    cur_tag = "reset_async";
    sb.push_back(RESET_VAL);
    cmp();
    @(negedge clk);
    cur_tag = "reset_held";
    sb.push_back(RESET_VAL);
    cmp();
    @(negedge clk);
    rst     = 1'b0;
    exp_cyc = 0;

    // Scan 0: reset snapshot (zeros); 1234 captured at its end
    cur_tag = "scan0_zeros";
    push_scan(16'h0000, 4'h0, 1'b0, 16, 0, 0);
    run(16);

    // Scan 1: 1234; input changes while index=1 must not tear it
    cur_tag = "scan1_1234";
    push_scan(16'h1234, 4'h0, 1'b0, 16, 0, 0);
    run(5);
    bus_if.bcd_in = 16'h9876;
    run(11);

    // Scan 2: 9876 (no leading zeros, so blank_lz has no effect)
    cur_tag = "scan2_9876";
    push_scan(16'h9876, 4'h0, 1'b1, 16, 0, 0);
    bus_if.blank_lz = 1'b1;
    bus_if.bcd_in   = 16'h0050;
    run(16);

    // Scan 3: 0050 with leading-zero blanking
    cur_tag = "scan3_lz_0050";
    push_scan(16'h0050, 4'h0, 1'b1, 16, 0, 0);
    bus_if.bcd_in = 16'h0000;
    run(16);

    // Scan 4: all zero, only digit 0 lit
    cur_tag = "scan4_lz_0000";
    push_scan(16'h0000, 4'h0, 1'b1, 16, 0, 0);
    bus_if.bcd_in = 16'h00A0;
    bus_if.dp_in  = 4'b0010;
    run(16);

    // Scan 5: invalid code dash plus decimal point on digit 1
    cur_tag = "scan5_dash_dp";
    push_scan(16'h00A0, 4'b0010, 1'b1, 16, 0, 0);
    run(16);

    // Scan 6: en low for three cycles blanks one cycle later, then resumes
    cur_tag = "scan6_enable";
    push_scan(16'h00A0, 4'b0010, 1'b1, 16, 2, 5);
    run(2);
    bus_if.en = 1'b0;
    run(3);
    bus_if.en = 1'b1;
    run(11);

    // Scan 7: async reset in the middle of digit 2
    cur_tag = "scan7_pre_rst";
    push_scan(16'h00A0, 4'b0010, 1'b1, 9, 0, 0);
    run(9);
    #2 rst = 1'b1;
    #1;
    cur_tag = "midscan_rst";
    sb.push_back(RESET_VAL);
    cmp();
    @(negedge clk);
    sb.push_back(RESET_VAL);
    cmp();
    rst     = 1'b0;
    exp_cyc = 0;

    // After release: digit 0 first, zero snapshot, blank_lz still on
    cur_tag = "post_rst_scan";
    push_scan(16'h0000, 4'h0, 1'b1, 16, 0, 0);
    run(16);

    // Next scan picks up the live 00A0 / dp 0010 again
    cur_tag = "post_rst_resume";
    push_scan(16'h00A0, 4'b0010, 1'b1, 16, 0, 0);
    run(16);

`ifdef BRIGHTNESS_PWM_EN
    // Reduced brightness: anode low only while pwm_cnt <= 3
    cur_tag = "pwm_duty3";
    bus_if.duty = 4'd3;
    push_scan(16'h00A0, 4'b0010, 1'b1, 16, 0, 0);
    run(16);
    cur_tag = "pwm_duty15";
    bus_if.duty = 4'd15;
    push_scan(16'h00A0, 4'b0010, 1'b1, 16, 0, 0);
    run(16);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
